// File: rtl/compound_accumulator.sv
// Load/accumulate register with a blocking read-response port; optional signed
// saturation on accumulate when COMPOUND_ACC_SAT_EN is defined.
module compound_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [33:0]      b_in,
    input  logic             b_in_sync,
    output logic             b_in_notify,
    output logic [33:0]      b_out,
    input  logic             b_out_sync,
    output logic             b_out_notify,
    output logic [CNT_W-1:0] count_o
);

    typedef enum logic {
        RD   = 1'b0,
        SEND = 1'b1
    } section_t;

    section_t         state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             clr_q, clr_d;
    logic [33:0]      b_out_q, b_out_d;
    logic             b_in_notify_q, b_in_notify_d;
    logic             b_out_notify_q, b_out_notify_d;

    logic             in_mode;
    logic [31:0]      in_x;
    logic             in_y;
    logic [31:0]      sum;
    logic             ovf_det;
    logic [31:0]      add_res;
    logic [CNT_W-1:0] count_inc;

    assign in_mode = b_in[33];
    assign in_x    = b_in[32:1];
    assign in_y    = b_in[0];

    // Signed overflow: operands agree in sign, result does not.
    assign sum     = acc_q + in_x;
    assign ovf_det = (acc_q[31] == in_x[31]) && (sum[31] != acc_q[31]);

`ifdef COMPOUND_ACC_SAT_EN
    always_comb begin
        add_res = sum;
        if (ovf_det) begin
            add_res = acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end
`else
    assign add_res = sum;
`endif

    assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        ovf_d          = ovf_q;
        count_d        = count_q;
        clr_d          = clr_q;
        b_out_d        = b_out_q;
        b_in_notify_d  = b_in_notify_q;
        b_out_notify_d = b_out_notify_q;
        case (state_q)
            RD: begin
                if (b_in_sync) begin
                    if (in_mode) begin
                        count_d = count_inc;
                        if (in_y) begin
                            acc_d = add_res;
                            ovf_d = ovf_q | ovf_det;
                        end else begin
                            acc_d = in_x;
                        end
                    end else begin
                        clr_d          = in_y;
                        b_out_d        = {1'b0, acc_q, ovf_q};
                        b_in_notify_d  = 1'b0;
                        b_out_notify_d = 1'b1;
                        state_d        = SEND;
                    end
                end
            end
            SEND: begin
                if (b_out_sync) begin
                    b_out_notify_d = 1'b0;
                    b_in_notify_d  = 1'b1;
                    state_d        = RD;
                    if (clr_q) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        count_d = '0;
                    end
                end
            end
            default: state_d = RD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RD;
            acc_q          <= '0;
            ovf_q          <= 1'b0;
            count_q        <= '0;
            clr_q          <= 1'b0;
            b_out_q        <= '0;
            b_in_notify_q  <= 1'b1;
            b_out_notify_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            ovf_q          <= ovf_d;
            count_q        <= count_d;
            clr_q          <= clr_d;
            b_out_q        <= b_out_d;
            b_in_notify_q  <= b_in_notify_d;
            b_out_notify_q <= b_out_notify_d;
        end
    end

    assign b_in_notify  = b_in_notify_q;
    assign b_out_notify = b_out_notify_q;
    assign b_out        = b_out_q;
    assign count_o      = count_q;

endmodule

// File: doc/compound_accumulator.md
Name: compound_accumulator

Overview:
- Downstream consumer of the CompoundType stream produced on a b_out-style blocking port.
- Accepts write transactions that load or accumulate x into a 32-bit register.
- On a read transaction, returns the accumulated value as a CompoundType response on its own blocking output port.
- Sits between the section-sequenced producer and the response sink.

Parameters:
CNT_W, 8, width of the saturating write-transaction counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
b_in  input  34  CompoundType {mode: 1 bit, read=0/write=1; x: signed 32; y: 1 bit}
b_in_sync  input  1  producer has valid b_in
b_in_notify  output  1  block ready to take b_in
b_out  output  34  CompoundType response
b_out_sync  input  1  consumer takes b_out
b_out_notify  output  1  b_out valid
count_o  output  CNT_W  writes accepted since last clear

Behaviour:
- Transfer rule: a transfer happens on a rising edge where notify and sync are both 1. All outputs are registered.
- Reset (async, rst=1):
  - section=RD, b_in_notify=1, b_out_notify=0, b_out={read,0,0}
  - acc=0, ovf=0, count_o=0
- State RD:
  - b_in_notify=1, b_out_notify=0.
  - Write with y=1: acc <= acc + x (32-bit wrap). ovf <= ovf | signed_overflow. count_o++.
  - Write with y=0: acc <= x (load); ovf unchanged. count_o++.
  - Both write cases stay in RD, so writes are accepted 1/cycle.
  - Read: latch clr <= b_in.y; b_out <= {read, acc, ovf}; b_in_notify <= 0; b_out_notify <= 1; go to SEND.
- State SEND:
  - b_out and b_out_notify are held stable until b_out_sync.
  - b_in_sync is ignored while in SEND.
  - On b_out_sync: b_out_notify <= 0, b_in_notify <= 1, go to RD. If clr: acc <= 0, ovf <= 0, count_o <= 0.
- Latency and ordering:
  - Read accepted at edge k gives b_out_notify=1 from cycle k+1; minimum read round trip is 2 cycles.
  - A write at edge k is visible to a read at edge k+1.
- Counter: count_o saturates at 2^CNT_W-1 and never wraps.
- Signed overflow: both operands have equal sign and the sum sign differs.
- Reset mid-SEND aborts the response: b_out_notify drops asynchronously and the state returns to RD with reset values.
- Unknown mode values cannot occur, since mode is 1 bit.

Optional Feature:
COMPOUND_ACC_SAT_EN
- Defined: accumulate uses signed saturation. Positive overflow clamps to 0x7FFFFFFF, negative overflow clamps to 0x80000000. ovf is still set on any clamp.
- Undefined: 32-bit two's-complement wrap; ovf is set on signed overflow.
- Load, read and clear behaviour are identical in both builds.

Test Plan:
- Reset -> b_in_notify=1, b_out_notify=0, b_out={read,0,0}, count_o=0; assert rst mid-SEND -> b_out_notify=0 immediately and acc reads 0 afterwards.
- Back-to-back writes {write,5,1},{write,7,1}, then {read,0,0} -> b_out={read,12,0} one cycle after acceptance, count_o=2.
- {write,100,0} after acc=12, then read -> x=100, count_o incremented by 1.
- Overflow: {write,0x7FFFFFFF,0},{write,1,1}, read -> x=0x80000000, y=1 without macro; x=0x7FFFFFFF, y=1 with COMPOUND_ACC_SAT_EN.
- Backpressure: read accepted, b_out_sync low 3 cycles -> b_out stable, b_in_notify=0, b_in_sync pulses ignored; sync high -> b_in_notify=1 next cycle.
- Clear: {read,0,1} after acc=12 -> response x=12; following read returns {read,0,0}, count_o=0. Then 260 writes with CNT_W=8 -> count_o=255.
